// File: rtl/hart_core.sv
// Barrel RV32I-subset core: NUM_HART threads share one datapath and retire
// one instruction per turn, round-robin. Fetch and data ports use a
// request/ack handshake with data returning the cycle after acceptance.
module hart_core #(
  parameter int unsigned NUM_HART       = 4,
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] imem_rd_addr,
  input  logic                      imem_rd_ack,
  input  logic [31:0]               imem_rd_data,
  output logic [MEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic                      dmem_rd_en,
  output logic                      dmem_wr_en,
  output logic [31:0]               dmem_wr_data,
  output logic [3:0]                dmem_wr_ben,
  input  logic                      dmem_rd_ack,
  input  logic                      dmem_wr_ack,
  input  logic [31:0]               dmem_rd_data
);

  localparam int unsigned HW = (NUM_HART > 1) ? $clog2(NUM_HART) : 1;
  localparam int unsigned AW = MEM_ADDR_WIDTH;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef enum logic [1:0] {StFetch, StDecode, StMem, StLoadWb} state_e;

  state_e                 state_q;
  logic [HW-1:0]          hart_q;
  logic [AW-1:0]          pc_q [NUM_HART];
  logic [REG_WIDTH-1:0]   rf_q [NUM_HART][32];
  logic [4:0]             ld_rd_q;
  logic [2:0]             ld_f3_q;
  logic [1:0]             ld_off_q;
  logic                   imem_rd_en_q, dmem_rd_en_q, dmem_wr_en_q;
  logic [AW-1:0]          imem_rd_addr_q, dmem_addr_q;
  logic [31:0]            dmem_wr_data_q;
  logic [3:0]             dmem_wr_ben_q;

  assign imem_rd_en   = imem_rd_en_q;
  assign imem_rd_addr = imem_rd_addr_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_rd_en   = dmem_rd_en_q;
  assign dmem_wr_en   = dmem_wr_en_q;
  assign dmem_wr_data = dmem_wr_data_q;
  assign dmem_wr_ben  = dmem_wr_ben_q;

  function automatic logic [REG_WIDTH-1:0] alu(input logic [2:0] f3,
                                               input logic [REG_WIDTH-1:0] a,
                                               input logic [REG_WIDTH-1:0] b,
                                               input logic alt);
    unique case (f3)
      3'b000:  alu = alt ? a - b : a + b;
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {{(REG_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      3'b011:  alu = {{(REG_WIDTH-1){1'b0}}, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? REG_WIDTH'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  logic [6:0]           opcode;
  logic [4:0]           rd, rs1, rs2;
  logic [2:0]           f3;
  logic [REG_WIDTH-1:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [REG_WIDTH-1:0] pc_cur, pc_plus4, pc_next, wb_val, mem_addr, ld_val;
  logic                 wb_en, is_ld, is_st, taken;
  logic [31:0]          st_data;
  logic [3:0]           st_ben;
  logic [HW-1:0]        hart_nxt;
  logic [AW-1:0]        fetch_alu, fetch_seq;
  logic                 unused_bits;

  // Decode and execute the instruction returned by the fetch port.
  always_comb begin
    opcode   = imem_rd_data[6:0];
    rd       = imem_rd_data[11:7];
    f3       = imem_rd_data[14:12];
    rs1      = imem_rd_data[19:15];
    rs2      = imem_rd_data[24:20];
    rs1_v    = rf_q[hart_q][rs1];
    rs2_v    = rf_q[hart_q][rs2];
    imm_i    = {{20{imem_rd_data[31]}}, imem_rd_data[31:20]};
    imm_s    = {{20{imem_rd_data[31]}}, imem_rd_data[31:25], imem_rd_data[11:7]};
    imm_b    = {{19{imem_rd_data[31]}}, imem_rd_data[31], imem_rd_data[7],
                imem_rd_data[30:25], imem_rd_data[11:8], 1'b0};
    imm_u    = {imem_rd_data[31:12], 12'b0};
    imm_j    = {{11{imem_rd_data[31]}}, imem_rd_data[31], imem_rd_data[19:12],
                imem_rd_data[20], imem_rd_data[30:21], 1'b0};
    pc_cur   = REG_WIDTH'(pc_q[hart_q]);
    pc_plus4 = pc_cur + 32'd4;
    pc_next  = pc_plus4;
    wb_en    = 1'b0;
    wb_val   = '0;
    is_ld    = 1'b0;
    is_st    = 1'b0;
    taken    = 1'b0;
    unique case (f3)
      3'b000:  taken = rs1_v == rs2_v;
      3'b001:  taken = rs1_v != rs2_v;
      3'b100:  taken = $signed(rs1_v) < $signed(rs2_v);
      3'b101:  taken = $signed(rs1_v) >= $signed(rs2_v);
      3'b110:  taken = rs1_v < rs2_v;
      3'b111:  taken = rs1_v >= rs2_v;
      default: taken = 1'b0;
    endcase
    unique case (opcode)
      OpLui:    begin wb_en = 1'b1; wb_val = imm_u; end
      OpAuipc:  begin wb_en = 1'b1; wb_val = pc_cur + imm_u; end
      OpJal:    begin wb_en = 1'b1; wb_val = pc_plus4; pc_next = pc_cur + imm_j; end
      OpJalr:   begin
        wb_en = 1'b1; wb_val = pc_plus4; pc_next = (rs1_v + imm_i) & ~32'd1;
      end
      OpBranch: if (taken) pc_next = pc_cur + imm_b;
      OpLoad:   is_ld = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
      OpStore:  is_st = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      OpImm:    begin
        wb_en = 1'b1; wb_val = alu(f3, rs1_v, imm_i, (f3 == 3'b101) && imem_rd_data[30]);
      end
      OpReg:    begin
        wb_en  = 1'b1;
        wb_val = alu(f3, rs1_v, rs2_v,
                     imem_rd_data[30] && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      default:  ;
    endcase
    mem_addr = rs1_v + (is_st ? imm_s : imm_i);
    unique case (f3[1:0])
      2'b00:   begin st_data = {4{rs2_v[7:0]}};  st_ben = 4'b0001 << mem_addr[1:0]; end
      2'b01:   begin st_data = {2{rs2_v[15:0]}}; st_ben = mem_addr[1] ? 4'b1100 : 4'b0011; end
      default: begin st_data = rs2_v;            st_ben = 4'b1111; end
    endcase
    hart_nxt  = (hart_q == HW'(NUM_HART - 1)) ? '0 : hart_q + 1'b1;
    // With a single hart the next fetch must see the PC being written now.
    fetch_alu = (hart_nxt == hart_q) ? pc_next[AW-1:0] : pc_q[hart_nxt];
    fetch_seq = (hart_nxt == hart_q) ? pc_plus4[AW-1:0] : pc_q[hart_nxt];
    unique case (ld_f3_q)
      3'b000:  ld_val = {{24{dmem_rd_data[{ld_off_q, 3'b111}]}},
                         dmem_rd_data[{ld_off_q, 3'b000} +: 8]};
      3'b100:  ld_val = {24'b0, dmem_rd_data[{ld_off_q, 3'b000} +: 8]};
      3'b001:  ld_val = ld_off_q[1] ? {{16{dmem_rd_data[31]}}, dmem_rd_data[31:16]}
                                    : {{16{dmem_rd_data[15]}}, dmem_rd_data[15:0]};
      3'b101:  ld_val = ld_off_q[1] ? {16'b0, dmem_rd_data[31:16]}
                                    : {16'b0, dmem_rd_data[15:0]};
      default: ld_val = dmem_rd_data;
    endcase
    unused_bits = ^{pc_next[REG_WIDTH-1:AW], pc_plus4[REG_WIDTH-1:AW],
                    mem_addr[REG_WIDTH-1:AW]};
  end

  // Sequencer: fetch, execute, optional memory phase, retire and rotate hart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StFetch;
      hart_q         <= '0;
      ld_rd_q        <= '0;
      ld_f3_q        <= '0;
      ld_off_q       <= '0;
      imem_rd_en_q   <= 1'b0;
      imem_rd_addr_q <= '0;
      dmem_addr_q    <= '0;
      dmem_rd_en_q   <= 1'b0;
      dmem_wr_en_q   <= 1'b0;
      dmem_wr_data_q <= '0;
      dmem_wr_ben_q  <= '0;
      for (int h = 0; h < int'(NUM_HART); h++) begin
        pc_q[h] <= '0;
        for (int r = 0; r < 32; r++) rf_q[h][r] <= '0;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_rd_en_q && imem_rd_ack) begin
            imem_rd_en_q <= 1'b0;
            state_q      <= StDecode;
          end else begin
            imem_rd_en_q   <= 1'b1;
            imem_rd_addr_q <= pc_q[hart_q];
          end
        end
        StDecode: begin
          if (is_ld || is_st) begin
            dmem_addr_q    <= mem_addr[AW-1:0];
            dmem_rd_en_q   <= is_ld;
            dmem_wr_en_q   <= is_st;
            dmem_wr_data_q <= is_st ? st_data : '0;
            dmem_wr_ben_q  <= is_st ? st_ben : '0;
            ld_rd_q        <= rd;
            ld_f3_q        <= f3;
            ld_off_q       <= mem_addr[1:0];
            state_q        <= StMem;
          end else begin
            if (wb_en && (rd != 5'd0)) rf_q[hart_q][rd] <= wb_val;
            pc_q[hart_q]   <= pc_next[AW-1:0];
            hart_q         <= hart_nxt;
            imem_rd_en_q   <= 1'b1;
            imem_rd_addr_q <= fetch_alu;
            state_q        <= StFetch;
          end
        end
        StMem: begin
          if (dmem_rd_en_q && dmem_rd_ack) begin
            dmem_rd_en_q <= 1'b0;
            dmem_addr_q  <= '0;
            state_q      <= StLoadWb;
          end else if (dmem_wr_en_q && dmem_wr_ack) begin
            dmem_wr_en_q   <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wr_data_q <= '0;
            dmem_wr_ben_q  <= '0;
            pc_q[hart_q]   <= pc_plus4[AW-1:0];
            hart_q         <= hart_nxt;
            imem_rd_en_q   <= 1'b1;
            imem_rd_addr_q <= fetch_seq;
            state_q        <= StFetch;
          end
        end
        StLoadWb: begin
          if (ld_rd_q != 5'd0) rf_q[hart_q][ld_rd_q] <= ld_val;
          pc_q[hart_q]   <= pc_plus4[AW-1:0];
          hart_q         <= hart_nxt;
          imem_rd_en_q   <= 1'b1;
          imem_rd_addr_q <= fetch_seq;
          state_q        <= StFetch;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hart_core.sv
// Directed bench for hart_core: behavioural instruction/data memories, fetch
// and store logs, and hand-computed expectations for each program.
module tb_hart_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_rd_en, imem_rd_ack;
  logic [11:0] imem_rd_addr, dmem_addr;
  logic [31:0] imem_rd_data, dmem_rd_data, dmem_wr_data;
  logic        dmem_rd_en, dmem_wr_en, dmem_rd_ack, dmem_wr_ack;
  logic [3:0]  dmem_wr_ben;
  logic        imem_stall = 1'b0;
  logic        dmem_stall = 1'b0;
  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic [31:0] dinit0 = '0;
  logic [31:0] dinit1 = '0;
  int          cyc;
  logic [31:0] f_addr[$];
  int          f_cyc[$];
  logic [31:0] s_addr[$], s_data[$], s_ben[$];
  int          checks = 0;
  int          errors = 0;

  hart_core #(.NUM_HART(4), .REG_WIDTH(32), .MEM_ADDR_WIDTH(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_rd_en   (imem_rd_en),
    .imem_rd_addr (imem_rd_addr),
    .imem_rd_ack  (imem_rd_ack),
    .imem_rd_data (imem_rd_data),
    .dmem_addr    (dmem_addr),
    .dmem_rd_en   (dmem_rd_en),
    .dmem_wr_en   (dmem_wr_en),
    .dmem_wr_data (dmem_wr_data),
    .dmem_wr_ben  (dmem_wr_ben),
    .dmem_rd_ack  (dmem_rd_ack),
    .dmem_wr_ack  (dmem_wr_ack),
    .dmem_rd_data (dmem_rd_data)
  );

  always #5 clk = ~clk;

  assign imem_rd_ack = !imem_stall;
  assign dmem_rd_ack = dmem_rd_en && !dmem_stall;
  assign dmem_wr_ack = dmem_wr_en && !dmem_stall;

  // Instruction memory: registered read of the accepted address.
  always @(posedge clk) begin
    if (imem_rd_en && imem_rd_ack) imem_rd_data <= imem[imem_rd_addr[7:2]];
  end

  // Data memory: reloads its two seed rows while reset is held.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) dmem[i] <= (i == 0) ? dinit0 : (i == 1) ? dinit1 : '0;
      dmem_rd_data <= '0;
    end else begin
      if (dmem_rd_en && dmem_rd_ack) dmem_rd_data <= dmem[dmem_addr[7:2]];
      if (dmem_wr_en && dmem_wr_ack) begin
        for (int b = 0; b < 4; b++)
          if (dmem_wr_ben[b]) dmem[dmem_addr[7:2]][8*b +: 8] <= dmem_wr_data[8*b +: 8];
      end
    end
  end

  // Logs of accepted fetches and stores, cleared while reset is held.
  always @(posedge clk) begin
    if (!rst) begin
      cyc <= 0;
      f_addr.delete(); f_cyc.delete();
      s_addr.delete(); s_data.delete(); s_ben.delete();
    end else begin
      cyc <= cyc + 1;
      if (imem_rd_en && imem_rd_ack) begin
        f_addr.push_back(32'(imem_rd_addr));
        f_cyc.push_back(cyc);
      end
      if (dmem_wr_en && dmem_wr_ack) begin
        s_addr.push_back(32'(dmem_addr));
        s_data.push_back(dmem_wr_data);
        s_ben.push_back(32'(dmem_wr_ben));
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_u(int imm, int rd, int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  // Enter reset and fill instruction memory with NOPs.
  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b0;
    imem_stall = 1'b0;
    dmem_stall = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] fa(int i);
    return (i < f_addr.size()) ? f_addr[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic int fc(int i);
    return (i < f_cyc.size()) ? f_cyc[i] : -1000;
  endfunction
  function automatic logic [31:0] sd(int i);
    return (i < s_data.size()) ? s_data[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    // Reset state: all outputs low while reset is asserted.
    #2 rst = 1'b0;
    #1;
    chk("rst_imem_en", 32'(imem_rd_en), 32'd0);
    chk("rst_dmem_en", {30'd0, dmem_rd_en, dmem_wr_en}, 32'd0);
    chk("rst_addrs", {8'd0, imem_rd_addr, dmem_addr}, 32'd0);
    chk("rst_wr", dmem_wr_data | 32'(dmem_wr_ben), 32'd0);

    // ADDI x1,x0,5 round-robin, then SW x1 to expose each hart's x1.
    hold_reset();
    imem[0] = 32'h0050_0093; imem[1] = 32'h0050_0093; imem[2] = 32'h0050_0093;
    imem[3] = enc_s(32'h40, 1, 0, 2);
    release_reset();
    repeat (60) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 12; i++) chk($sformatf("fetch_seq%0d", i), fa(i), 32'((i / 4) * 4));
    chk("alu_cycles", 32'(fc(5) - fc(4)), 32'd2);
    chk("n_x1_stores", 32'(s_data.size()), 32'd4);
    for (int h = 0; h < 4; h++) chk($sformatf("x1_hart%0d", h), sd(h), 32'd5);
    chk("sw_ben", (s_ben.size() > 0) ? s_ben[0] : 32'hF0, 32'hF);

    // Loads of every width and sign against seeded rows.
    hold_reset();
    dinit0 = 32'h0123_4567; dinit1 = 32'h80F0_FF85;
    imem[0] = enc_i(0, 0, 2, 2, 7'h03);
    imem[1] = enc_i(1, 0, 4, 3, 7'h03);
    imem[2] = enc_i(2, 0, 1, 4, 7'h03);
    imem[3] = enc_i(0, 0, 0, 5, 7'h03);
    imem[4] = enc_i(4, 0, 0, 6, 7'h03);
    imem[5] = enc_i(6, 0, 5, 7, 7'h03);
    for (int k = 0; k < 6; k++) imem[6 + k] = enc_s(32'h40 + 4 * k, k + 2, 0, 2);
    imem[12] = enc_b(0, 0, 0, 0);
    release_reset();
    repeat (220) @(posedge clk);
    @(negedge clk);
    chk("load_cycles", 32'(fc(1) - fc(0)), 32'd4);
    chk("n_ld_stores", 32'(s_data.size() >= 24), 32'd1);
    chk("lw", sd(0), 32'h0123_4567);
    chk("lbu", sd(4), 32'h0000_0045);
    chk("lh", sd(8), 32'h0000_0123);
    chk("lb_pos", sd(12), 32'h0000_0067);
    chk("lb_neg", sd(16), 32'hFFFF_FF85);
    chk("lhu", sd(20), 32'h0000_80F0);
    chk("lw_hart3", sd(3), 32'h0123_4567);

    // Byte and half stores: lane replication and byte enables.
    hold_reset();
    dinit0 = 32'h0123_4567; dinit1 = 32'h0;
    imem[0] = enc_i(32'hAB, 0, 0, 1, 7'h13);
    imem[1] = enc_s(2, 1, 0, 0);
    imem[2] = enc_s(6, 1, 0, 1);
    imem[3] = enc_b(0, 0, 0, 0);
    release_reset();
    repeat (80) @(posedge clk);
    @(negedge clk);
    chk("store_cycles", 32'(fc(5) - fc(4)), 32'd3);
    chk("n_st", 32'(s_data.size()), 32'd8);
    chk("sb_addr", (s_addr.size() > 0) ? s_addr[0] : 32'hFFF, 32'h2);
    chk("sb_ben", (s_ben.size() > 0) ? s_ben[0] : 32'hF0, 32'b0100);
    chk("sb_data", sd(0), 32'hABAB_ABAB);
    chk("sh_ben", (s_ben.size() > 4) ? s_ben[4] : 32'hF0, 32'b1100);
    chk("sh_data", sd(4), 32'h00AB_00AB);
    chk("row0", dmem[0], 32'h01AB_4567);
    chk("row1", dmem[1], 32'h00AB_0000);

    // JAL link/target, backward JAL, then BEQ self-loop at PC 8.
    hold_reset();
    imem[0] = enc_j(16, 1);
    imem[4] = enc_s(32'h40, 1, 0, 2);
    imem[5] = enc_j(-12, 0);
    imem[2] = enc_b(0, 0, 0, 0);
    release_reset();
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("jal_target", fa(4), 32'd16);
    chk("jal_back", fa(8), 32'd20);
    chk("loop_a", fa(12), 32'd8);
    chk("loop_b", fa(19), 32'd8);
    chk("jal_link_h0", sd(0), 32'd4);
    chk("jal_link_h3", sd(3), 32'd4);

    // SUB/SRAI/SLTU, signed and unsigned branches, LUI, AUIPC.
    hold_reset();
    imem[0]  = enc_i(8, 0, 0, 5, 7'h13);
    imem[1]  = enc_r(32'h20, 5, 0, 0, 1);
    imem[2]  = enc_i(32'h401, 1, 5, 2, 7'h13);
    imem[3]  = enc_r(0, 1, 0, 3, 3);
    imem[4]  = enc_b(8, 0, 1, 4);
    imem[5]  = enc_i(99, 0, 0, 3, 7'h13);
    imem[6]  = enc_b(8, 1, 0, 7);
    imem[7]  = enc_u(32'h12345, 4, 7'h37);
    imem[8]  = enc_u(1, 6, 7'h17);
    imem[9]  = enc_s(32'h40, 1, 0, 2);
    imem[10] = enc_s(32'h44, 2, 0, 2);
    imem[11] = enc_s(32'h48, 3, 0, 2);
    imem[12] = enc_s(32'h4C, 4, 0, 2);
    imem[13] = enc_s(32'h50, 6, 0, 2);
    imem[14] = enc_b(0, 0, 0, 0);
    release_reset();
    repeat (220) @(posedge clk);
    @(negedge clk);
    chk("sub", sd(0), 32'hFFFF_FFF8);
    chk("srai", sd(4), 32'hFFFF_FFFC);
    chk("sltu_blt", sd(8), 32'd1);
    chk("lui_bgeu", sd(12), 32'h1234_5000);
    chk("auipc", sd(16), 32'h0000_1020);
    chk("srai_h3", sd(7), 32'hFFFF_FFFC);

    // Fetch stall: request and address hold, nothing is accepted.
    hold_reset();
    imem[0] = 32'h0050_0093;
    imem_stall = 1'b1;
    release_reset();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall_en%0d", i), 32'(imem_rd_en), 32'd1);
      chk($sformatf("stall_addr%0d", i), 32'(imem_rd_addr), 32'd0);
      chk($sformatf("stall_noacc%0d", i), 32'(f_addr.size()), 32'd0);
    end
    imem_stall = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("stall_resume", 32'(f_addr.size() > 0), 32'd1);

    // Reset asserted while a load waits in the memory phase.
    hold_reset();
    dinit0 = 32'h0123_4567;
    imem[0] = enc_i(0, 0, 2, 2, 7'h03);
    dmem_stall = 1'b1;
    release_reset();
    for (int i = 0; i < 20 && !dmem_rd_en; i++) @(negedge clk);
    chk("midld_req", 32'(dmem_rd_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("midld_en", {29'd0, imem_rd_en, dmem_rd_en, dmem_wr_en}, 32'd0);
    chk("midld_addr", {8'd0, imem_rd_addr, dmem_addr}, 32'd0);
    dmem_stall = 1'b0;
    release_reset();
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("midld_pc0", fa(0), 32'd0);
    chk("midld_pc1", fa(1), 32'd0);
    chk("midld_gap", 32'(fc(1) - fc(0)), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
